display_scan_sched: RTL
=======================

// Module: display_scan_sched
// PURPOSE
//  Scan scheduler for the 4-digit 7-segment display; drives the 4:1 digit-data mux directly.
//  Produces the 2-bit digit select s, active-low anodes an, and active-low decimal point dp.
//  Inserts a blanking interval around every digit change so the segment data never ghosts.
//  Sits between the system clock and the digit-data mux/segment decoder.
// PARAMETERS
//  SCAN_DIV   100000  clk cycles a digit is lit per slot (legal: >=2)
//  BLANK_CYC  256     clk cycles all anodes are off between digits (legal: >=1)
//  CNT_W      17      prescaler width; must hold max(SCAN_DIV,BLANK_CYC)-1
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  en          in   1  1 = scanning runs; 0 = display dark, scan parked
//  digit_en    in   4  per-digit enable mask; bit i=0 keeps digit i dark in its slot
//  point       in   4  per-digit decimal point request, bit i for digit i
//  s           out  2  digit select to the 4:1 mux (0..3)
//  an          out  4  anodes, active-low, at most one bit low
//  dp          out  1  decimal point, active-low
//  frame_tick  out  1  1-cycle pulse when digit 0 is entered (once per 4-digit frame)
// BEHAVIOUR
//  - All outputs registered. Reset: s=0, an=4'b1111, dp=1, frame_tick=0, state=IDLE, cnt=0.
//  - FSM states IDLE, SHOW, BLANK.
//    IDLE : an=1111, dp=1, s=0. First edge with en=1 -> SHOW, s=0, cnt=0, frame_tick=1.
//    SHOW : an[s]=~digit_en[s], other bits 1; dp=~(point[s]&digit_en[s]). cnt++ each cycle;
//           at cnt==SCAN_DIV-1 -> BLANK, cnt=0, an=1111, dp=1 at that edge.
//    BLANK: an=1111, dp=1, s unchanged. At cnt==BLANK_CYC-1 -> SHOW, cnt=0, s=s+1 (3 wraps
//           to 0, frame_tick=1 on the wrap); new s and its anode update on the same edge.
//  - Slot period = SCAN_DIV+BLANK_CYC cycles; frame = 4 slots. Disabled digits still
//    consume their slot (uniform brightness); they are never skipped.
//  - digit_en/point sampled every SHOW cycle: changes appear on an/dp 1 cycle later.
//  - s changes only on the BLANK->SHOW edge or to 0 on entry to IDLE; never while lit.
//  - en=0 in any state -> next edge IDLE: an=1111, dp=1, s=0, cnt=0. en=1 again restarts
//    at digit 0 with frame_tick.
//  - rst in any state overrides en and forces reset values on the same edge.
//  - frame_tick high exactly one cycle; never high in IDLE or BLANK.
// STRUCTURE
//  - Package display_pkg: NUM_DIG=4, SEL_W=2, AN_OFF=4'b1111, typedef enum
//    scan_state_t {IDLE,SHOW,BLANK}; shared with the mux/decoder stage.
//  - One sub-module: scan_prescaler (CNT_W counter, clear input, terminal-count output
//    compared against a runtime limit selected by state: SCAN_DIV-1 or BLANK_CYC-1).
//  - Top: FSM, select counter, registered anode/dp decode.
// TESTING (bench uses SCAN_DIV=4, BLANK_CYC=2 -> 6-cycle slot, 24-cycle frame)
//  1 rst=1 3 cycles, en=0 -> an=1111, dp=1, s=0, frame_tick=0 throughout.
//  2 rst=0, en=1, digit_en=1111 -> an=1110 for 4 cycles, 1111 for 2, then s=1 an=1101;
//    sequence 1110/1101/1011/0111 repeats; frame_tick every 24 cycles.
//  3 digit_en=1010, point=1111 -> slots 0,2 dark (an=1111,dp=1); slot1 an=1101 dp=0;
//    slot 3 an=0111 dp=0; frame period still 24 cycles.
//  4 Drop en mid-SHOW of digit 2 -> next edge an=1111, s=0; re-raise en -> an=1110 and
//    frame_tick=1 on first edge.
//  5 Assert rst for 1 cycle during BLANK of digit 3 -> reset values next edge; no wrap tick.
//  6 Assertion checks over 10k random cycles w/ random en/digit_en: $countones(~an)<=1;
//    s stable whenever an!=1111 on consecutive cycles; an=1111 for >=2 cycles between digits.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment scan path (scheduler, digit mux,
// segment decoder).
//   NUM_DIG / SEL_W : digit count and width of the digit select
//   AN_OFF          : anode pattern with every digit dark (active-low)
//   scan_state_t    : scheduler FSM states
//   an_decode()     : active-low one-cold anode pattern for a lit digit
package display_pkg;
   localparam int NUM_DIG = 4;
   localparam int SEL_W   = 2;
   localparam logic [NUM_DIG-1:0] AN_OFF = 4'b1111;

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t;

   // A masked digit keeps its anode high but still owns its slot.
   function automatic logic [NUM_DIG-1:0] an_decode(input logic [SEL_W-1:0]   sel,
                                                    input logic [NUM_DIG-1:0] den);
      logic [NUM_DIG-1:0] a;
      a      = AN_OFF;
      a[sel] = ~den[sel];
      return a;
   endfunction
endpackage

// File: rtl/scan_prescaler.sv
// Slot/blank duration counter for the scan scheduler.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : restart the count at 0 on the next edge
//   limit_i  : terminal value for the current interval
//   tc_o     : count has reached limit_i (combinational)
module scan_prescaler #(
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             tc_o
);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) cnt_q <= '0;
      else              cnt_q <= cnt_q + CNT_W'(1);
   end

   assign tc_o = (cnt_q == limit_i);
endmodule

// File: rtl/display_scan_sched.sv
// Scan scheduler for the 4-digit 7-segment display. Steps the digit select,
// drives active-low anodes and decimal point, and inserts an all-dark blanking
// interval between digits so segment data never ghosts.
//   clk, rst   : clock, synchronous active-high reset
//   en         : 1 = scan runs, 0 = display dark and scan parked at digit 0
//   digit_en   : per-digit enable mask (0 = digit dark in its slot)
//   point      : per-digit decimal point request
//   s          : digit select to the 4:1 data mux
//   an         : anodes, active-low, at most one low
//   dp         : decimal point, active-low
//   frame_tick : one-cycle pulse whenever digit 0 is entered
module display_scan_sched
   import display_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 256,
   parameter int CNT_W     = 17
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_DIG-1:0] digit_en,
   input  logic [NUM_DIG-1:0] point,
   output logic [SEL_W-1:0]   s,
   output logic [NUM_DIG-1:0] an,
   output logic               dp,
   output logic               frame_tick
);
   localparam logic [CNT_W-1:0] SHOW_LIM  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC - 1);

   scan_state_t        state_q, state_d;
   logic [SEL_W-1:0]   s_q, s_d;
   logic [NUM_DIG-1:0] an_q, an_d;
   logic               dp_q, dp_d;
   logic               tick_q, tick_d;
   logic               tc;
   logic               cnt_clr;

   // Counter restarts on every interval boundary and is held at 0 while parked,
   // so the first SHOW after enable starts at 0.
   assign cnt_clr = !en || (state_q == IDLE) || tc;

   scan_prescaler #(.CNT_W(CNT_W)) u_presc (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .limit_i ((state_q == SHOW) ? SHOW_LIM : BLANK_LIM),
      .tc_o    (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = SHOW;
            SHOW:    if (tc) state_d = BLANK;
            BLANK:   if (tc) state_d = SHOW;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are computed from the next state so an/dp/s/tick change on the
   // same edge as the state they belong to.
   always_comb begin
      s_d    = s_q;
      tick_d = 1'b0;
      case (state_d)
         IDLE: s_d = '0;
         SHOW: begin
            if (state_q == IDLE) begin
               s_d    = '0;
               tick_d = 1'b1;
            end else if (state_q == BLANK) begin
               s_d    = s_q + 1'b1;
               tick_d = (s_q == SEL_W'(NUM_DIG - 1));
            end
         end
         default: ;
      endcase
      if (state_d == SHOW) begin
         an_d = an_decode(s_d, digit_en);
         dp_d = ~(point[s_d] & digit_en[s_d]);
      end else begin
         an_d = AN_OFF;
         dp_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= '0;
         an_q   <= AN_OFF;
         dp_q   <= 1'b1;
         tick_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         an_q   <= an_d;
         dp_q   <= dp_d;
         tick_q <= tick_d;
      end
   end

   assign s          = s_q;
   assign an         = an_q;
   assign dp         = dp_q;
   assign frame_tick = tick_q;
endmodule
